// File: rtl/register_file_if.sv
// Register file access bundle.
// Read addresses, write port and read data.
interface register_file_if #(
  parameter int WIDTH = 64
);
  logic [4:0]       RA;
  logic [4:0]       RB;
  logic [4:0]       RW;
  logic             RegWr;
  logic [WIDTH-1:0] BusW;
  logic [WIDTH-1:0] BusA;
  logic [WIDTH-1:0] BusB;

  modport master (
    output RA, RB, RW, RegWr, BusW,
    input  BusA, BusB
  );

  modport slave (
    input  RA, RB, RW, RegWr, BusW,
    output BusA, BusB
  );
endinterface

// File: rtl/register_file.sv
// Two-read one-write register file, X31 reads zero.
// Reads are combinational with write-through bypass.
module register_file #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 32
) (
  input logic            Clk,
  input logic            Reset,
  register_file_if.slave bus
);
  localparam logic [4:0] ZR = 5'(DEPTH - 1);

  logic [WIDTH-1:0] regs_q [DEPTH-1];
  logic             wr_en;

  assign wr_en = bus.RegWr & ~Reset & (bus.RW != ZR);

  // Storage: async clear, write on rising edge
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[bus.RW] <= bus.BusW;
    end
  end

  // Read ports: zero for XZR or reset, else bypass or stored value
  always_comb begin
    bus.BusA = '0;
    bus.BusB = '0;
    if (!Reset && bus.RA != ZR) begin
      if (wr_en && bus.RW == bus.RA) begin
        bus.BusA = bus.BusW;
      end else begin
        bus.BusA = regs_q[bus.RA];
      end
    end
    if (!Reset && bus.RB != ZR) begin
      if (wr_en && bus.RW == bus.RB) begin
        bus.BusB = bus.BusW;
      end else begin
        bus.BusB = regs_q[bus.RB];
      end
    end
  end
endmodule

// File: tb/tb_register_file.sv
// Register file bench: directed cases plus random traffic
// compared every cycle against an array model.
module tb_register_file;
  logic clk;
  logic rst;
  bit   run;
  int   n_chk;
  int   n_fail;

  logic [63:0] mdl [32];

  register_file_if #(.WIDTH(64)) bus ();

  register_file #(
    .WIDTH(64),
    .DEPTH(32)
  ) dut (
    .Clk  (clk),
    .Reset(rst),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] rd(input logic [4:0] a);
    if (rst || a == 5'd31) return 64'd0;
    if (bus.RegWr && bus.RW == a) return bus.BusW;
    return mdl[a];
  endfunction

  task automatic clr_mdl();
    for (int i = 0; i < 32; i++) mdl[i] = 64'd0;
  endtask

  task automatic drv(input logic [4:0] ra,
                     input logic [4:0] rb,
                     input logic [4:0] rw,
                     input logic we,
                     input logic [63:0] w);
    bus.RA = ra;
    bus.RB = rb;
    bus.RW = rw;
    bus.RegWr = we;
    bus.BusW = w;
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!rst && bus.RegWr && bus.RW != 5'd31)
      mdl[bus.RW] = bus.BusW;
    #1;
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (run) begin
      chk("cyc_busA", bus.BusA, rd(bus.RA));
      chk("cyc_busB", bus.BusB, rd(bus.RB));
    end
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    run = 1'b0;
    rst = 1'b1;
    clr_mdl();
    drv(5'd0, 5'd0, 5'd0, 1'b0, 64'd0);
    #1;
    run = 1'b1;

    for (int i = 0; i < 32; i++) begin
      drv(5'(i), 5'(31 - i), 5'($urandom_range(0, 31)),
          1'b1, {$urandom, $urandom});
      #1;
      chk("rst_busA", bus.BusA, 64'd0);
      chk("rst_busB", bus.BusB, 64'd0);
      cyc();
    end
    rst = 1'b0;

    drv(5'd0, 5'd0, 5'd1, 1'b1, 64'hAB);
    cyc();
    drv(5'd1, 5'd0, 5'd0, 1'b0, 64'd0);
    #1;
    chk("first_wr", bus.BusA, 64'hAB);

    drv(5'd0, 5'd0, 5'd5, 1'b1, 64'h0123456789ABCDEF);
    cyc();
    drv(5'd0, 5'd0, 5'd30, 1'b1, 64'hFFFFFFFFFFFFFFFF);
    cyc();
    drv(5'd5, 5'd30, 5'd0, 1'b0, 64'd0);
    #1;
    chk("rb_x5", bus.BusA, 64'h0123456789ABCDEF);
    chk("rb_x30", bus.BusB, 64'hFFFFFFFFFFFFFFFF);

    drv(5'd31, 5'd31, 5'd31, 1'b1, 64'hDEAD);
    #1;
    chk("xzr_same", bus.BusA, 64'd0);
    cyc();
    drv(5'd31, 5'd31, 5'd0, 1'b0, 64'd0);
    #1;
    chk("xzr_next", bus.BusA, 64'd0);

    drv(5'd0, 5'd0, 5'd7, 1'b1, 64'h10);
    cyc();
    drv(5'd7, 5'd7, 5'd7, 1'b1, 64'h20);
    #1;
    chk("byp_A", bus.BusA, 64'h20);
    chk("byp_B", bus.BusB, 64'h20);
    bus.BusW = 64'h21;
    #1;
    chk("byp_prop", bus.BusA, 64'h21);
    bus.BusW = 64'h20;
    cyc();
    bus.RegWr = 1'b0;
    #1;
    chk("byp_after", bus.BusA, 64'h20);

    drv(5'd0, 5'd0, 5'd3, 1'b1, 64'h33);
    cyc();
    drv(5'd0, 5'd0, 5'd3, 1'b0, 64'h55);
    repeat (3) cyc();
    bus.RA = 5'd3;
    #1;
    chk("no_wr", bus.BusA, 64'h33);

    drv(5'd0, 5'd0, 5'd9, 1'b1, 64'h77);
    cyc();
    drv(5'd9, 5'd9, 5'd9, 1'b1, 64'h88);
    #1;
    chk("mid_byp", bus.BusA, 64'h88);
    rst = 1'b1;
    clr_mdl();
    #1;
    chk("mid_rst_hold", bus.BusA, 64'd0);
    rst = 1'b0;
    bus.RegWr = 1'b0;
    #1;
    chk("mid_rst_clr", bus.BusA, 64'd0);
    bus.RegWr = 1'b1;
    cyc();
    bus.RegWr = 1'b0;
    #1;
    chk("mid_rst_wr", bus.BusA, 64'h88);

    for (int n = 0; n < 2000; n++) begin
      drv(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
          5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
          {$urandom, $urandom});
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        clr_mdl();
        #1;
        rst = 1'b0;
      end
      cyc();
    end

    @(negedge clk);
    run = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter WIDTH, default 64: data width of each register and bus.
REQ-002 SHALL have parameter DEPTH, default 32: number of architectural registers X0..X31.
REQ-003 SHALL have port Clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port RA, input, 5 bits: read address for port A.
REQ-006 SHALL have port RB, input, 5 bits: read address for port B.
REQ-007 SHALL have port RW, input, 5 bits: write address.
REQ-008 SHALL have port RegWr, input, 1 bit: write enable.
REQ-009 SHALL have port BusW, input, WIDTH bits: write data, sourced from the writeback mux fed by the ALU busW or memory.
REQ-010 SHALL have port BusA, output, WIDTH bits: read data A, feeding ALU busA.
REQ-011 SHALL have port BusB, output, WIDTH bits: read data B, feeding the ALUSrc mux ahead of ALU busB.

Function
REQ-012 SHALL hold DEPTH registers of WIDTH bits, X0..X30 writable and X31 hardwired to zero (XZR).
REQ-013 SHALL drive BusA and BusB combinationally from RA and RB, with zero clock latency.
REQ-014 SHALL drive 0 on a read port whose address is 31, regardless of any write.
REQ-015 SHALL write BusW into register RW on the rising edge of Clk when RegWr=1, Reset=0, and RW!=31.
REQ-016 SHALL ignore writes to RW=31: no state change, and later reads of X31 return 0.
REQ-017 SHALL leave all registers unchanged on any edge where RegWr=0.
REQ-018 SHALL bypass writes to reads: when RegWr=1, Reset=0, RW!=31 and RW==RA, BusA SHALL equal BusW in the same cycle, before the edge.
REQ-019 SHALL apply the same bypass to port B when RW==RB.
REQ-020 SHALL give both ports the identical value, including any bypass, when RA==RB.
REQ-021 SHALL have outputs that depend only on register contents and current inputs; there is no hidden pipeline state.
REQ-022 SHALL let BusW changes propagate to a bypassed output combinationally, with no latching of BusW before the edge.
REQ-023 SHALL produce no X on BusA or BusB after reset for any RA or RB value.

Reset
REQ-024 SHALL clear all registers to 0 immediately when Reset rises, independent of Clk.
REQ-025 SHALL hold BusA=0 and BusB=0 while Reset=1, with writes suppressed and bypass disabled.
REQ-026 SHALL, when Reset asserts mid-cycle with RegWr=1, discard the pending write; the register reads 0 after Reset deasserts.
REQ-027 SHALL accept the first write on the first rising Clk edge at which Reset is sampled 0.

Verification
REQ-028 SHALL be tested for reset: assert Reset, sweep RA and RB over 0..31 -> BusA=BusB=0 for every address.
REQ-029 SHALL be tested for write/readback: write X5=0x0123456789ABCDEF, then X30=0xFFFFFFFFFFFFFFFF; next cycle RA=5, RB=30 -> BusA=0x0123456789ABCDEF, BusB=0xFFFFFFFFFFFFFFFF.
REQ-030 SHALL be tested for XZR: RegWr=1, RW=31, BusW=0xDEAD; RA=31 in the same and next cycle -> BusA=0 both cycles.
REQ-031 SHALL be tested for bypass: X7=0x10 stored; RegWr=1, RW=7, BusW=0x20, RA=RB=7 before the edge -> BusA=BusB=0x20; after the edge with RegWr=0 -> 0x20.
REQ-032 SHALL be tested for no-write: RegWr=0, RW=3, BusW=0x55 over several edges -> X3 still reads its prior value.
REQ-033 SHALL be tested for mid-operation reset: X9=0x77 stored; pulse Reset between edges while RegWr=1, RW=9, BusW=0x88 -> X9 reads 0 after release; the next edge with RegWr=1 writes 0x88.
